// File: rtl/decode_scan_ctrl.sv
// Sequencer for the dual 2-to-4 decoder stage: sweeps codes 0..3 on bank A,
// bank B, or A then B, holding each code for DWELL cycles. All outputs registered.
module decode_scan_ctrl #(
  parameter int DWELL   = 4,
  parameter int DWELL_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode,
  output logic [1:0] x,
  output logic [1:0] y,
  output logic       en1,
  output logic       en2,
  output logic       s,
  output logic       busy,
  output logic       sweep_done
);

  if (DWELL < 1 || DWELL >= (1 << DWELL_W)) begin : g_bad_dwell
    $error("decode_scan_ctrl: DWELL must be in 1..2**DWELL_W-1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_A = 2'd1,
    RUN_B = 2'd2
  } state_e;

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

  state_e             state_q, state_d;
  logic [1:0]         code_q, code_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [1:0]         mode_q, mode_d;
  logic               sweep_q, sweep_d;
  logic [1:0]         x_q, x_d, y_q, y_d;
  logic               en1_q, en1_d, en2_q, en2_d, s_q, s_d, busy_q, busy_d;

  logic last_dwell;
  assign last_dwell = (dwell_q == DWELL_LAST);

  // NOTE: every variable driven here gets a default first, so no path
  // through the case/if tree can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    dwell_d = dwell_q;
    mode_d  = mode_q;
    sweep_d = 1'b0;

    if (stop) begin
      state_d = IDLE;
      code_d  = 2'd0;
      dwell_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            mode_d  = mode;
            code_d  = 2'd0;
            dwell_d = '0;
            state_d = (mode == 2'b01) ? RUN_B : RUN_A;
          end
        end
        RUN_A, RUN_B: begin
          if (last_dwell) begin
            dwell_d = '0;
            code_d  = code_q + 2'd1;
            if (code_q == 2'd3) begin
              // A->B hand-off continues the same sweep; every other bank end
              // starts a new one.
              if (state_q == RUN_A) begin
                if (mode_q[1]) state_d = RUN_B;
                else           sweep_d = 1'b1;
              end else begin
                if (mode_q[1]) state_d = RUN_A;
                sweep_d = 1'b1;
              end
            end
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they register on the same edge.
    x_d    = (state_d == RUN_A) ? code_d : 2'd0;
    y_d    = (state_d == RUN_B) ? code_d : 2'd0;
    en1_d  = (state_d == RUN_A);
    en2_d  = (state_d == RUN_B);
    s_d    = (state_d == RUN_B);
    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= 2'd0;
      dwell_q <= '0;
      mode_q  <= 2'd0;
      sweep_q <= 1'b0;
      x_q     <= 2'd0;
      y_q     <= 2'd0;
      en1_q   <= 1'b0;
      en2_q   <= 1'b0;
      s_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
      sweep_q <= sweep_d;
      x_q     <= x_d;
      y_q     <= y_d;
      en1_q   <= en1_d;
      en2_q   <= en2_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign en1        = en1_q;
  assign en2        = en2_q;
  assign s          = s_q;
  assign busy       = busy_q;
  assign sweep_done = sweep_q;

endmodule

// File: tb/tb_decode_scan_ctrl.sv
// Self-checking bench for decode_scan_ctrl (DWELL=2): directed scenarios plus
// randomized start/stop/mode traffic against a cycle-count based reference model.
module tb_decode_scan_ctrl;

  localparam int DW = 2;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [1:0] x, y;
  logic       en1, en2, s, busy, sweep_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: run flag, latched mode, cycles elapsed since first code-0 cycle.
  bit       m_run  = 1'b0;
  bit [1:0] m_mode = 2'b00;
  int       m_t    = 0;

  decode_scan_ctrl #(.DWELL(DW), .DWELL_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .x          (x),
    .y          (y),
    .en1        (en1),
    .en2        (en2),
    .s          (s),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] got_vec();
    return {x, y, en1, en2, s, busy, sweep_done};
  endfunction

  // Expected {x,y,en1,en2,s,busy,sweep_done} from elapsed time and mode.
  function automatic logic [8:0] model_out();
    int       p;
    logic [1:0] c;
    logic     on_b;
    logic     sd;
    if (!m_run) return 9'd0;
    if (m_mode == 2'b00 || m_mode == 2'b01) begin
      on_b = (m_mode == 2'b01);
      c    = 2'((m_t / DW) % 4);
      sd   = (m_t > 0) && (m_t % (4 * DW) == 0);
    end else begin
      p    = m_t % (8 * DW);
      on_b = (p >= 4 * DW);
      c    = 2'((p % (4 * DW)) / DW);
      sd   = (m_t > 0) && (p == 0);
    end
    return {on_b ? 2'd0 : c, on_b ? c : 2'd0, ~on_b, on_b, on_b, 1'b1, sd};
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, sample 1ns later.
  task automatic step(input logic st, input logic sp, input logic [1:0] md);
    start = st;
    stop  = sp;
    mode  = md;
    @(posedge clk);
    if (sp) begin
      m_run = 1'b0;
    end else if (!m_run && st) begin
      m_run  = 1'b1;
      m_mode = md;
      m_t    = 0;
    end else if (m_run) begin
      m_t++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    mode  = 2'b00;
    #3;
    n_checks++;
    if (got_vec() !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_init: got %b expected %b", got_vec(), 9'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 2'b10);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'b10);
    #2;
    rst_n = 1'b0;
    m_run = 1'b0;
    #1;
    n_checks++;
    if (got_vec() !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_async: got %b expected %b", got_vec(), 9'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 2'b00);
      n_checks++;
      if (got_vec() !== model_out()) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: got %b expected %b", i, got_vec(), model_out());
      end
    end
  endtask

  task automatic test_mode_a();
    int first_sd = -1;
    step(1'b1, 1'b0, 2'b00);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc > 1) step(1'b0, 1'b0, 2'b00);
      n_checks++;
      if (got_vec() !== model_out()) begin
        n_fail++;
        $display("FAIL mode_a cyc %0d: got %b expected %b", cyc, got_vec(), model_out());
      end
      if (sweep_done && first_sd < 0) first_sd = cyc;
    end
    n_checks++;
    if (first_sd !== 9) begin
      n_fail++;
      $display("FAIL mode_a_sweep_latency: got %0d expected 9", first_sd);
    end
    step(1'b0, 1'b1, 2'b00);
  endtask

  task automatic test_mode_ab();
    int n_sd = 0;
    step(1'b1, 1'b0, 2'b10);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc > 1) step(1'b0, 1'b0, 2'b10);
      n_checks++;
      if (got_vec() !== model_out()) begin
        n_fail++;
        $display("FAIL mode_ab cyc %0d: got %b expected %b", cyc, got_vec(), model_out());
      end
      n_checks++;
      if ((en1 & en2) !== 1'b0) begin
        n_fail++;
        $display("FAIL mode_ab_en_overlap cyc %0d: got en1=%b en2=%b expected not both 1", cyc, en1, en2);
      end
      if (sweep_done) n_sd++;
    end
    n_checks++;
    if (n_sd !== 2) begin
      n_fail++;
      $display("FAIL mode_ab_sweep_count: got %0d expected 2", n_sd);
    end
    step(1'b0, 1'b1, 2'b10);
  endtask

  task automatic test_stop_end_of_bank();
    step(1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 2'b00);
    n_checks++;
    if (x !== 2'd3) begin
      n_fail++;
      $display("FAIL stop_eob_setup: got x=%0d expected 3", x);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, (i == 0), 2'b00);
      n_checks++;
      if (got_vec() !== 9'd0) begin
        n_fail++;
        $display("FAIL stop_eob cyc %0d: got %b expected %b", i, got_vec(), 9'd0);
      end
    end
  endtask

  task automatic test_ignored_inputs();
    step(1'b1, 1'b0, 2'b00);
    for (int cyc = 1; cyc <= 24; cyc++) begin
      if (cyc > 1) step(1'(cyc % 3 == 0), 1'b0, (cyc > 4) ? 2'b01 : 2'b00);
      n_checks++;
      if (got_vec() !== model_out()) begin
        n_fail++;
        $display("FAIL ignored_inputs cyc %0d: got %b expected %b", cyc, got_vec(), model_out());
      end
    end
    step(1'b0, 1'b1, 2'b00);
  endtask

  task automatic test_start_stop_idle();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 2'b10);
      n_checks++;
      if (got_vec() !== 9'd0) begin
        n_fail++;
        $display("FAIL start_stop_idle cyc %0d: got %b expected %b", i, got_vec(), 9'd0);
      end
    end
    step(1'b1, 1'b0, 2'b01);
    // Expected: x=0, y=0, en1=0, en2=1, s=1, busy=1, sweep_done=0.
    n_checks++;
    if (got_vec() !== 9'b00_00_0_1_1_1_0) begin
      n_fail++;
      $display("FAIL mode_b_first: got %b expected %b", got_vec(), 9'b000001110);
    end
    for (int cyc = 2; cyc <= 18; cyc++) begin
      step(1'b0, 1'b0, 2'b00);
      n_checks++;
      if (got_vec() !== model_out()) begin
        n_fail++;
        $display("FAIL mode_b cyc %0d: got %b expected %b", cyc, got_vec(), model_out());
      end
    end
    step(1'b0, 1'b1, 2'b00);
  endtask

  task automatic test_random();
    logic st, sp;
    logic [1:0] md;
    for (int cyc = 0; cyc < 600; cyc++) begin
      st = ($urandom_range(0, 7) == 0);
      sp = ($urandom_range(0, 59) == 0);
      md = 2'($urandom_range(0, 3));
      step(st, sp, md);
      n_checks++;
      if (got_vec() !== model_out()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %b expected %b", cyc, got_vec(), model_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode_a();
    test_mode_ab();
    test_stop_end_of_bank();
    test_ignored_inputs();
    test_start_stop_idle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
